// File: rtl/crash_monitor_if.sv
// Pixel/sync inputs and game outputs of the crash monitor. The signal names match the
// original Verilog ports, so existing connections can map across one for one.
interface crash_monitor_if;
  logic        vs;
  logic        game_status;
  logic        px_dinosaur;
  logic        px_obstacle;
  logic        pixel_valid;
  logic        crash;
  logic        game_over;
  logic [15:0] score;

  modport master (
    output vs, game_status, px_dinosaur, px_obstacle, pixel_valid,
    input  crash, game_over, score
  );

  modport slave (
    input  vs, game_status, px_dinosaur, px_obstacle, pixel_valid,
    output crash, game_over, score
  );
endinterface

// File: rtl/crash_monitor.sv
// Counts dinosaur/obstacle overlap pixels in each frame and raises a crash at the end of
// any frame that reaches HIT_THRESHOLD. It scores one BCD point every SCORE_DIV clean frames.
module crash_monitor #(
  parameter int unsigned SCORE_DIV     = 6,
  parameter int unsigned HIT_THRESHOLD = 4
) (
  input logic            CLK,
  input logic            RESET,
  crash_monitor_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] OVER = 2'd2;

  localparam logic [7:0] FRAME_LAST = 8'(SCORE_DIV - 1);
  localparam logic [7:0] HIT_LVL    = 8'(HIT_THRESHOLD);

  logic [1:0]  r_state;
  logic        r_vs_d;
  logic [7:0]  r_overlap;
  logic [7:0]  r_frame;
  logic [15:0] r_score;
  logic        r_crash;
  logic        r_game_over;

  logic        w_boundary;
  logic        w_overlap_px;
  logic [15:0] w_score_inc;
  logic        w_carry;

  assign w_boundary   = r_vs_d & ~bus.vs;
  assign w_overlap_px = bus.vs & bus.pixel_valid & bus.px_dinosaur & bus.px_obstacle;

  // Ripple BCD increment. A score of 9999 holds instead of wrapping.
  always_comb begin
    w_score_inc = r_score;
    w_carry     = 1'b1;
    if (r_score != 16'h9999) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_carry) begin
          if (r_score[i*4 +: 4] == 4'd9) begin
            w_score_inc[i*4 +: 4] = 4'd0;
          end else begin
            w_score_inc[i*4 +: 4] = r_score[i*4 +: 4] + 4'd1;
            w_carry               = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_vs_d      <= 1'b1;
      r_overlap   <= '0;
      r_frame     <= '0;
      r_score     <= '0;
      r_crash     <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_vs_d  <= bus.vs;
      r_crash <= 1'b0;
      case (r_state)
        IDLE: begin
          r_game_over <= 1'b0;
          r_overlap   <= '0;
          if (bus.game_status) begin
            r_state <= RUN;
            r_score <= '0;
            r_frame <= '0;
          end
        end
        RUN: begin
          // A stop request overrides a coincident crash or score update.
          if (!bus.game_status) begin
            r_state   <= IDLE;
            r_overlap <= '0;
          end else if (w_boundary) begin
            r_overlap <= '0;
            if (r_overlap >= HIT_LVL) begin
              r_state     <= OVER;
              r_crash     <= 1'b1;
              r_game_over <= 1'b1;
            end else if (r_frame == FRAME_LAST) begin
              r_frame <= '0;
              r_score <= w_score_inc;
            end else begin
              r_frame <= r_frame + 8'd1;
            end
          end else if (w_overlap_px && (r_overlap != 8'hFF)) begin
            r_overlap <= r_overlap + 8'd1;
          end
        end
        OVER: begin
          r_overlap <= '0;
          if (!bus.game_status) begin
            r_state     <= IDLE;
            r_game_over <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_overlap   <= '0;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  assign bus.crash     = r_crash;
  assign bus.game_over = r_game_over;
  assign bus.score     = r_score;

endmodule

// File: tb/tb_crash_monitor.sv
// Scoreboard bench for crash_monitor. One instance uses the default score divider and a
// second uses SCORE_DIV=1, so BCD saturation is reached within a short run.
module tb_crash_monitor;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  crash_monitor_if if0();
  crash_monitor_if if1();

  assign if1.vs          = if0.vs;
  assign if1.game_status = if0.game_status;
  assign if1.px_dinosaur = if0.px_dinosaur;
  assign if1.px_obstacle = if0.px_obstacle;
  assign if1.pixel_valid = if0.pixel_valid;

  crash_monitor #(.SCORE_DIV(6), .HIT_THRESHOLD(4)) dut0 (.CLK(CLK), .RESET(RESET), .bus(if0.slave));
  crash_monitor #(.SCORE_DIV(1), .HIT_THRESHOLD(4)) dut1 (.CLK(CLK), .RESET(RESET), .bus(if1.slave));

  logic [17:0] out_w [2];
  assign out_w[0] = {if0.crash, if0.game_over, if0.score};
  assign out_w[1] = {if1.crash, if1.game_over, if1.score};

  int compared   = 0;
  int mismatched = 0;

  logic [17:0] q0 [$];
  logic [17:0] q1 [$];
  int          n   [2];
  int          f   [2];
  int          dv  [2] = '{6, 1};
  logic [17:0] cur [2];
  int          st;            // 0 idle, 1 run, 2 over
  bit          mon_on = 1'b0;

  function automatic logic [15:0] bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_out(input int k, input logic [17:0] v);
    if (v !== cur[k]) begin
      if (k == 0) q0.push_back(v);
      else        q1.push_back(v);
      cur[k] = v;
    end
  endtask

  task automatic model_boundary(input bit crash_exp);
    if (st == 1) begin
      for (int k = 0; k < 2; k++) begin
        if (crash_exp) begin
          expect_out(k, {2'b11, bcd(n[k])});
          expect_out(k, {2'b01, bcd(n[k])});
        end else begin
          f[k]++;
          if (f[k] == dv[k]) begin
            f[k] = 0;
            if (n[k] < 9999) n[k]++;
            expect_out(k, {2'b00, bcd(n[k])});
          end
        end
      end
      if (crash_exp) st = 2;
    end
  endtask

  task automatic set_gs(input bit v);
    if0.game_status = v;
    for (int k = 0; k < 2; k++) begin
      if (v && st == 0) begin
        f[k] = 0;
        n[k] = 0;
        expect_out(k, 18'h0);
      end else if (!v && st != 0) begin
        expect_out(k, {2'b00, bcd(n[k])});
      end
    end
    if (v && st == 0) st = 1;
    else if (!v)      st = 0;
    tick();
  endtask

  task automatic px(input bit d, input bit o, input bit v);
    if0.vs          = 1'b1;
    if0.px_dinosaur = d;
    if0.px_obstacle = o;
    if0.pixel_valid = v;
    tick();
  endtask

  // Overlaps, masked overlaps, two near-miss pixels, then blanking with an overlap on the
  // boundary cycle itself (vs=0 there, so it must not count).
  task automatic frame(input int nov, input int ninv, input bit exp_crash, input bit drop_gs);
    for (int i = 0; i < nov; i++)  px(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < ninv; i++) px(1'b1, 1'b1, 1'b0);
    px(1'b1, 1'b0, 1'b1);
    px(1'b0, 1'b1, 1'b1);
    if0.vs          = 1'b0;
    if0.px_dinosaur = 1'b1;
    if0.px_obstacle = 1'b1;
    if0.pixel_valid = 1'b1;
    if (drop_gs) begin
      if0.game_status = 1'b0;
      for (int k = 0; k < 2; k++) expect_out(k, {2'b00, bcd(n[k])});
      st = 0;
    end else begin
      model_boundary(exp_crash);
    end
    tick();
    if0.px_dinosaur = 1'b0;
    if0.px_obstacle = 1'b0;
    tick();
  endtask

  task automatic fast_frame();
    px(1'b0, 1'b0, 1'b1);
    if0.vs = 1'b0;
    model_boundary(1'b0);
    tick();
  endtask

  // Monitor: every change of {crash, game_over, score} must match the next expected entry.
  initial begin
    logic [17:0] prev [2];
    bit          cw   [2];
    logic [17:0] nowv, e;
    wait (mon_on);
    prev[0] = out_w[0];
    prev[1] = out_w[1];
    cw[0]   = 1'b0;
    cw[1]   = 1'b0;
    forever begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        nowv = out_w[k];
        if (nowv !== prev[k]) begin
          compared++;
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            mismatched++;
            $display("FAIL unexpected_out dut%0d: got %h expected no change", k, nowv);
          end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            if (nowv !== e) begin
              mismatched++;
              $display("FAIL out_event dut%0d: got %h expected %h", k, nowv, e);
            end
          end
          prev[k] = nowv;
        end
        if (nowv[17]) begin
          compared++;
          if (cw[k]) begin
            mismatched++;
            $display("FAIL crash_width dut%0d: got crash high 2 cycles expected 1", k);
          end
        end
        cw[k] = nowv[17];
      end
    end
  end

  initial begin
    RESET           = 1'b1;
    if0.vs          = 1'b0;
    if0.game_status = 1'b0;
    if0.px_dinosaur = 1'b0;
    if0.px_obstacle = 1'b0;
    if0.pixel_valid = 1'b0;
    repeat (3) tick();
    check("reset_dut0", out_w[0], 18'h0);
    check("reset_dut1", out_w[1], 18'h0);
    RESET  = 1'b0;
    cur[0] = 18'h0;
    cur[1] = 18'h0;
    n[0] = 0; n[1] = 0; f[0] = 0; f[1] = 0;
    st     = 0;
    mon_on = 1'b1;
    repeat (2) tick();

    set_gs(1'b1);
    repeat (6) frame(0, 0, 1'b0, 1'b0);
    frame(3, 2, 1'b0, 1'b0);
    frame(3, 0, 1'b0, 1'b0);
    frame(4, 0, 1'b1, 1'b0);
    frame(5, 0, 1'b0, 1'b0);
    set_gs(1'b0);
    frame(4, 0, 1'b0, 1'b0);

    set_gs(1'b1);
    repeat (7) frame(0, 0, 1'b0, 1'b0);
    frame(5, 0, 1'b0, 1'b1);
    frame(2, 0, 1'b0, 1'b0);

    set_gs(1'b1);
    repeat (6) frame(0, 0, 1'b0, 1'b0);
    repeat (3) px(1'b1, 1'b1, 1'b1);
    RESET           = 1'b1;
    if0.game_status = 1'b0;
    for (int k = 0; k < 2; k++) begin
      expect_out(k, 18'h0);
      n[k] = 0;
      f[k] = 0;
    end
    st = 0;
    tick();
    check("midreset_dut0", out_w[0], 18'h0);
    check("midreset_dut1", out_w[1], 18'h0);
    tick();
    RESET  = 1'b0;
    if0.vs = 1'b0;
    repeat (2) tick();
    set_gs(1'b1);
    frame(3, 0, 1'b0, 1'b0);
    frame(4, 0, 1'b1, 1'b0);
    set_gs(1'b0);
    set_gs(1'b1);

    repeat (10006) fast_frame();

    for (int i = 0; i < 50 && (q0.size() != 0 || q1.size() != 0); i++) tick();
    compared++;
    if (q0.size() != 0 || q1.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    check("final_dut0", out_w[0], {2'b00, bcd(n[0])});
    check("final_dut1", out_w[1], {2'b00, 16'h9999});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/crash_monitor.md
CRASH_MONITOR -- requirements
Module: crash_monitor

Interface
REQ-001 The block SHALL have parameter SCORE_DIV, default 6, giving the number of completed frames per score increment (legal range 1..255).
REQ-002 The block SHALL have parameter HIT_THRESHOLD, default 4, giving the number of overlapping pixels in one frame that constitutes a crash (legal range 1..255).
REQ-003 The block SHALL have port CLK  input  1  the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port vs  input  1  VGA vertical sync; 0 = blanking, 1 = active frame.
REQ-006 The block SHALL have port game_status  input  1  1 = game running, 0 = stopped.
REQ-007 The block SHALL have port px_dinosaur  input  1  the dinosaur sprite covers the current pixel.
REQ-008 The block SHALL have port px_obstacle  input  1  an obstacle covers the current pixel.
REQ-009 The block SHALL have port pixel_valid  input  1  the current pixel is in the visible area.
REQ-010 The block SHALL have port crash  output  1  one-cycle request to stop the game.
REQ-011 The block SHALL have port game_over  output  1  level; 1 from crash until game_status returns to 0.
REQ-012 The block SHALL have port score  output  16  four packed BCD digits, with [15:12] as the most significant digit.

Function
REQ-013 The block SHALL implement states IDLE, RUN and OVER.
REQ-014 A frame boundary SHALL be the cycle where registered vs_d=1 and vs=0 (falling edge of vs).
REQ-015 An overlap pixel SHALL be any cycle with vs=1, pixel_valid=1, px_dinosaur=1 and px_obstacle=1.
REQ-016 In RUN, overlap pixels SHALL increment an 8-bit overlap counter that saturates at 255.
REQ-017 The overlap counter SHALL be cleared on every frame boundary and on every state change.
REQ-018 In IDLE, on game_status=1: next state RUN; score cleared to 0x0000 on the same edge; frame counter and overlap counter cleared.
REQ-019 At a frame boundary in RUN with overlap counter >= HIT_THRESHOLD, the block SHALL go to OVER, assert crash for exactly one cycle, set game_over=1, and leave score unchanged.
REQ-020 At a frame boundary in RUN with overlap counter < HIT_THRESHOLD, the block SHALL increment the frame counter. When the frame counter equals SCORE_DIV-1, it SHALL instead wrap the frame counter to 0 and increment score by 1 in BCD.
REQ-021 BCD increment: a digit at 9 SHALL wrap to 0 and carry into the next digit; score SHALL saturate at 0x9999.
REQ-022 The comparison in REQ-019 SHALL use the counter value before the boundary-cycle clear. An overlap on the boundary cycle itself is not counted, because vs=0 on that cycle.
REQ-023 In RUN, game_status=0 SHALL return the block to IDLE with no crash, regardless of a coincident frame boundary. game_status=0 has priority over crash and over score increment.
REQ-024 In OVER, game_over SHALL stay 1, score SHALL be held, and overlaps SHALL be ignored. game_status=0 SHALL return the block to IDLE with game_over cleared on the same edge.
REQ-025 In IDLE, score SHALL hold its last value and crash and game_over SHALL be 0.
REQ-026 Latency: crash and game_over SHALL be registered and SHALL assert on the clock edge after the boundary cycle. Score SHALL update on that same edge.

Reset
REQ-027 RESET=1 at a clock edge SHALL force: state IDLE, vs_d=1, overlap counter 0, frame counter 0, score 0x0000, crash 0, game_over 0.
REQ-028 RESET SHALL take priority over all other inputs, including mid-frame and in OVER.
REQ-029 After RESET is released, the first frame boundary SHALL be detected only after vs has been seen as 1 for at least one cycle.

Verification
REQ-030 Scenario: RESET, then game_status=1, then 6 frames with no overlap -> score=0x0001 after frame 6, crash never asserted.
REQ-031 Scenario: RUN with 4 overlap pixels in one frame, then vs falls -> crash=1 for exactly one cycle, game_over=1, score unchanged; game_status=0 -> game_over=0, state IDLE.
REQ-032 Scenario: 3 overlap pixels plus 2 pixels with pixel_valid=0 in one frame -> no crash; the frame counts toward score.
REQ-033 Scenario: preload score to 0x0999 via frames, then one score increment -> 0x1000. Further drive score to 0x9999 plus one more increment -> score stays 0x9999.
REQ-034 Scenario: game_status falls on the same cycle as a crashing frame boundary -> no crash, state IDLE, game_over=0.
REQ-035 Scenario: RESET asserted mid-frame in RUN with overlap counter=3 -> all outputs 0 next cycle; game_status=1 restarts with score=0x0000.
